// File: rtl/phase_sequencer.sv
// Per-instruction micro-step controller: accepts one opcode, runs an 8-phase window,
// and fires up to three selector read strobes with their select codes.
module phase_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] opcode,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       stall,
    output logic       clock_3,
    output logic       clock_5,
    output logic       clock_7,
    output logic [3:0] select_1,
    output logic [3:0] select_2,
    output logic [3:0] select_3,
    output logic       done,
    output logic [2:0] eip_step,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] steps;
        logic [3:0] sel1;
        logic [3:0] sel2;
        logic [3:0] sel3;
        logic [2:0] eip;
    } decode_t;

    function automatic decode_t decode_op(input logic [7:0] op);
        decode_t d;
        d = '0;
        case (op)
            8'h90: d = '{legal: 1'b1, steps: 2'd0, sel1: 4'h0, sel2: 4'h0, sel3: 4'h0, eip: 3'd1};
            8'h89: d = '{legal: 1'b1, steps: 2'd1, sel1: 4'h2, sel2: 4'h0, sel3: 4'h0, eip: 3'd2};
            8'h55: d = '{legal: 1'b1, steps: 2'd2, sel1: 4'h5, sel2: 4'h2, sel3: 4'h0, eip: 3'd1};
            8'h5D: d = '{legal: 1'b1, steps: 2'd2, sel1: 4'h4, sel2: 4'h2, sel3: 4'h0, eip: 3'd1};
            // CALL and RET leave EIP to the datapath, so they advance by zero.
            8'hE8: d = '{legal: 1'b1, steps: 2'd3, sel1: 4'h7, sel2: 4'h2, sel3: 4'h2, eip: 3'd0};
            8'hC3: d = '{legal: 1'b1, steps: 2'd3, sel1: 4'h4, sel2: 4'h2, sel3: 4'h2, eip: 3'd0};
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] ph_q, ph_d;
    logic [1:0] steps_q, steps_d;
    logic [3:0] sel1_q, sel1_d;
    logic [3:0] sel2_q, sel2_d;
    logic [3:0] sel3_q, sel3_d;
    logic [2:0] eip_q, eip_d;
    logic       fault_q, fault_d;
    decode_t    dec;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        steps_d = steps_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        sel3_d  = sel3_q;
        eip_d   = eip_q;
        fault_d = fault_q;
        dec     = decode_op(opcode);
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (dec.legal) begin
                        state_d = S_RUN;
                        ph_d    = 3'd0;
                        steps_d = dec.steps;
                        sel1_d  = dec.sel1;
                        sel2_d  = dec.sel2;
                        sel3_d  = dec.sel3;
                        eip_d   = dec.eip;
                    end else begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (ph_q == 3'd7) begin
                        state_d = S_IDLE;
                        ph_d    = 3'd0;
                        steps_d = 2'd0;
                        sel1_d  = 4'h0;
                        sel2_d  = 4'h0;
                        sel3_d  = 4'h0;
                        eip_d   = 3'd0;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = 3'd0;
                steps_d = 2'd0;
                sel1_d  = 4'h0;
                sel2_d  = 4'h0;
                sel3_d  = 4'h0;
                eip_d   = 3'd0;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ph_q    <= 3'd0;
            steps_q <= 2'd0;
            sel1_q  <= 4'h0;
            sel2_q  <= 4'h0;
            sel3_q  <= 4'h0;
            eip_q   <= 3'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            steps_q <= steps_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            sel3_q  <= sel3_d;
            eip_q   <= eip_d;
            fault_q <= fault_d;
        end
    end

    logic       fire;
    logic [2:0] strobe;

    assign fire = (state_q == S_RUN) && !stall;

    // Step gi fires at phase 3+2*gi, only if the opcode uses at least gi+1 steps.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
            assign strobe[gi] = fire && (ph_q == 3'(3 + 2 * gi)) && (steps_q > 2'(gi));
        end
    endgenerate

    assign clock_3     = strobe[0];
    assign clock_5     = strobe[1];
    assign clock_7     = strobe[2];
    assign done        = fire && (ph_q == 3'd7);
    assign eip_step    = done ? eip_q : 3'd0;
    assign instr_ready = (state_q == S_IDLE);
    assign fault       = fault_q;
    assign select_1    = sel1_q;
    assign select_2    = sel2_q;
    assign select_3    = sel3_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a cycle model of the instruction window
// plus a scoreboard of per-instruction results popped on each done pulse.
module tb_phase_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       stall = 1'b0;
    logic       clock_3, clock_5, clock_7;
    logic [3:0] select_1, select_2, select_3;
    logic       done;
    logic [2:0] eip_step;
    logic       fault;

    phase_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .clock_3     (clock_3),
        .clock_5     (clock_5),
        .clock_7     (clock_7),
        .select_1    (select_1),
        .select_2    (select_2),
        .select_3    (select_3),
        .done        (done),
        .eip_step    (eip_step),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       legal;
        logic [1:0] steps;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [2:0] eip;
    } exp_t;

    function automatic exp_t ref_table(input logic [7:0] op);
        exp_t e;
        e = '0;
        case (op)
            8'h90: e = '{1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 3'd1};
            8'h89: e = '{1'b1, 2'd1, 4'h2, 4'h0, 4'h0, 3'd2};
            8'h55: e = '{1'b1, 2'd2, 4'h5, 4'h2, 4'h0, 3'd1};
            8'h5D: e = '{1'b1, 2'd2, 4'h4, 4'h2, 4'h0, 3'd1};
            8'hE8: e = '{1'b1, 2'd3, 4'h7, 4'h2, 4'h2, 3'd0};
            8'hC3: e = '{1'b1, 2'd3, 4'h4, 4'h2, 4'h2, 3'd0};
            default: e = '0;
        endcase
        return e;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state, advanced once per cycle at the falling edge.
    logic       m_run = 1'b0;
    logic       m_fault = 1'b0;
    logic [2:0] m_ph = 3'd0;
    exp_t       m_cur = '0;

    always @(negedge clock) begin
        exp_t e;
        logic m_fire;
        if (!reset_n) begin
            m_run   = 1'b0;
            m_fault = 1'b0;
            m_ph    = 3'd0;
            m_cur   = '0;
            exp_q.delete();
        end
        m_fire = m_run && !stall;
        check("clock_3", 32'(clock_3), 32'(m_fire && m_ph == 3'd3 && m_cur.steps >= 2'd1));
        check("clock_5", 32'(clock_5), 32'(m_fire && m_ph == 3'd5 && m_cur.steps >= 2'd2));
        check("clock_7", 32'(clock_7), 32'(m_fire && m_ph == 3'd7 && m_cur.steps >= 2'd3));
        check("done", 32'(done), 32'(m_fire && m_ph == 3'd7));
        check("instr_ready", 32'(instr_ready), 32'(!m_run && !m_fault));
        check("fault", 32'(fault), 32'(m_fault));
        check("selects", 32'({select_1, select_2, select_3}),
              m_run ? 32'({m_cur.s1, m_cur.s2, m_cur.s3}) : 32'h0);
        if (!done) check("eip_idle", 32'(eip_step), 32'h0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("eip_step", 32'(eip_step), 32'(e.eip));
                check("select_3_at_done", 32'(select_3), 32'(e.s3));
                $display("DONE  cyc=%0d eip_step=%0d sel=%0h/%0h/%0h",
                         cyc + 1, eip_step, select_1, select_2, select_3);
            end
        end
        if (reset_n) begin
            if (!m_run && !m_fault && instr_valid) begin
                acc_cnt++;
                acc_cyc = cyc + 1;
                e = ref_table(opcode);
                $display("ACCEPT cyc=%0d opcode=%02h legal=%0d", acc_cyc, opcode, e.legal);
                if (e.legal) begin
                    m_run = 1'b1;
                    m_ph  = 3'd0;
                    m_cur = e;
                    exp_q.push_back(e);
                end else begin
                    m_fault = 1'b1;
                end
            end else if (m_fire) begin
                if (m_ph == 3'd7) begin
                    m_run = 1'b0;
                    m_cur = '0;
                end else begin
                    m_ph = m_ph + 3'd1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Present op and return 2 ns after the accepting edge.
    task automatic send(input logic [7:0] op);
        int n0;
        bit got;
        tick(1);
        opcode      = op;
        instr_valid = 1'b1;
        n0  = acc_cnt;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clock);
            if (acc_cnt != n0) got = 1'b1;
        end
        if (!got) check("accept_timeout", 32'h0, 32'h1);
        #2;
        instr_valid = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clock);
            if (instr_ready) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", 32'h0, 32'h1);
        tick(1);
    endtask

    initial begin
        int t1;
        int t2;
        logic [7:0] ops [6];
        ops[0] = 8'h90; ops[1] = 8'h89; ops[2] = 8'h55;
        ops[3] = 8'h5D; ops[4] = 8'hE8; ops[5] = 8'hC3;

        tick(3);
        reset_n = 1'b1;
        tick(2);

        send(8'h55);
        wait_ready(20);
        tick(2);

        send(8'hE8);
        wait_ready(20);

        send(8'hC3);
        tick(2);
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        wait_ready(20);

        stall = 1'b1;
        send(8'h90);
        stall = 1'b0;
        wait_ready(20);

        tick(1);
        opcode      = 8'h90;
        instr_valid = 1'b1;
        t1 = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == t1; i++) @(posedge clock);
        t1 = acc_cyc;
        #2;
        opcode = 8'h89;
        t2 = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == t2; i++) @(posedge clock);
        check("b2b_gap", 32'(acc_cyc - t1), 32'd9);
        #2;
        instr_valid = 1'b0;
        wait_ready(20);

        send(8'h00);
        instr_valid = 1'b0;
        tick(20);
        opcode      = 8'h90;
        instr_valid = 1'b1;
        tick(4);
        instr_valid = 1'b0;
        reset_n     = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        send(8'h55);
        tick(3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(12);

        for (int k = 0; k < 8; k++) begin
            send(ops[$urandom_range(0, 5)]);
            for (int c = 0; c < 14; c++) begin
                stall = ($urandom_range(0, 3) == 0);
                tick(1);
            end
            stall = 1'b0;
            wait_ready(30);
        end

        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
